gradient_calc_pipe: RTL
=======================

Name: gradient_calc_pipe

Overview:
- Parametrised successor to gradient_calculation: 3x3 window in, gradient magnitude, 4-way quantised direction and clipped per-axis magnitudes out.
- Adds runtime kernel selection (Sobel/Prewitt/Scharr) and magnitude mode (L1 or approximate L2).
- Uses a 3-stage elastic pipeline with valid/ready backpressure and a per-frame edge counter.
- Sits between the second pixel_loader (window source) and non-maximum suppression.

Parameters:
- PIXEL_W, 8, bits per pixel.
- MAG_W, 11, output magnitude width; saturating.
- CNT_W, 19, edge counter width; saturating.

Ports:
- clk  in  1  clock.
- rstN  in  1  reset.
- win_in  in  9*PIXEL_W  3x3 window. Pixel (r,c) at bits [(3r+c)*PIXEL_W +: PIXEL_W]; r=0 is the top row, c=0 is the left column.
- win_in_valid  in  1  window valid.
- win_in_ready  out  1  block accepts window.
- win_in_sof  in  1  window is first of a frame.
- kernel_sel  in  2  0=Sobel, 1=Prewitt, 2=Scharr, 3=reserved (treated as Sobel). Sampled with each window.
- mag_sel  in  1  0=L1, 1=approx L2. Sampled with each window.
- edge_thresh  in  MAG_W  edge count threshold. Sampled at output handshake.
- gradient_magnitude  out  MAG_W  saturated magnitude.
- gradient_direction  out  2  0=horizontal gradient, 1=45 deg, 2=vertical, 3=135 deg.
- pixel_out_x  out  PIXEL_W  min(|Gx|, 2^PIXEL_W-1).
- pixel_out_y  out  PIXEL_W  min(|Gy|, 2^PIXEL_W-1).
- gradient_out_valid  out  1  output valid.
- gradient_out_ready  in  1  downstream accepts.
- gradient_out_sof  out  1  sof carried with the data.
- edge_count  out  CNT_W  edges in the current frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rstN is synchronous, active-low. On reset, all stage valids, all outputs and edge_count go to 0; win_in_ready is 1 once out of reset.
- Kernels:
  - Gx = sum over r of w_r*(p[r][2]-p[r][0]); Gy = sum over c of w_c*(p[2][c]-p[0][c]).
  - Weights (w0,w1,w2): Sobel (1,2,1), Prewitt (1,1,1), Scharr (3,10,3).
  - Gx and Gy are signed, PIXEL_W+6 bits; no overflow is possible.
- S1 registers Gx, Gy, mag_sel, sof.
- S2 registers ax=|Gx|, ay=|Gy|, sdiff=(Gx<0)^(Gy<0), raw magnitude:
  - L1: ax+ay.
  - L2: max + (min>>2) + (min>>3). Shifts truncate.
- S3 registers the outputs:
  - Magnitude saturates to 2^MAG_W-1.
  - Direction:
    - 256*ay <= 106*ax -> 0;
    - else 256*ay >= 618*ax -> 2;
    - else sdiff=0 -> 1, sdiff=1 -> 3.
  - Zero gradient -> direction 0, magnitude 0.
- Handshake:
  - Stage k ready = !valid_k || ready_(k+1); ready_4 = gradient_out_ready.
  - win_in_ready = ready_1 (combinational).
  - Transfer occurs when valid && ready. Bubbles collapse.
  - Latency is 3 cycles from input handshake to gradient_out_valid when never stalled; throughput 1 per cycle.
  - While gradient_out_valid && !gradient_out_ready, outputs hold stable.
  - No data is lost or reordered.
- Edge counter, updated on output handshake only:
  - hit = (gradient_magnitude >= edge_thresh).
  - If gradient_out_sof: edge_count <= hit.
  - Else edge_count <= edge_count + hit, saturating at 2^CNT_W-1.
- Reset mid-stream: in-flight data is discarded, outputs are 0 the following cycle, and no partial output is emitted.
- Input behaviour when the block is not ready: win_in_valid while not ready is held by upstream; the block does not sample it.

Decomposition:
- edge_pkg holds:
  - kernel_e enum;
  - dir_e enum (DIR_H=0, DIR_45=1, DIR_V=2, DIR_135=3);
  - TAN22_Q8=106 and TAN67_Q8=618;
  - the Sobel/Prewitt/Scharr weight constants.
- Sub-module gradient_dir_quant (combinational): ax, ay, sdiff -> dir_e. It is reused by NMS.

Test Plan:
- Sobel, L1, left column 0, right column 255, all else 128 -> magnitude 1020, direction 0, x=255, y=0, valid 3 cycles after accept.
- Scharr, same window -> Gx=4080, magnitude saturates to 2047, direction 0.
- Sobel, p=50*(r+c) -> Gx=Gy=400: L1 gives 800, L2 gives 550, direction 1. With p=50*(c+2-r) -> direction 3.
- Continuous input 10 windows, gradient_out_ready low for cycles 4..8 -> win_in_ready falls within 1 cycle of output stall; all 10 outputs emerge in order; outputs stable while stalled.
- edge_thresh=500: frame A of 4 windows (2 above threshold), then sof window above threshold -> edge_count 2 after frame A, then 1.
- rstN low for 1 cycle with 2 windows in flight -> next cycle gradient_out_valid=0, edge_count=0, nothing emitted afterward until new input.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection datapath (gradient and NMS).
package edge_pkg;

  typedef enum logic [1:0] {
    K_SOBEL   = 2'd0,
    K_PREWITT = 2'd1,
    K_SCHARR  = 2'd2,
    K_RSVD    = 2'd3
  } kernel_e;

  typedef enum logic [1:0] {
    DIR_H   = 2'd0,
    DIR_45  = 2'd1,
    DIR_V   = 2'd2,
    DIR_135 = 2'd3
  } dir_e;

  // tan(22.5 deg) and tan(67.5 deg) in Q8
  localparam int TAN22_Q8 = 106;
  localparam int TAN67_Q8 = 618;

  // Kernel weights (w0, w1, w2); all kernels are symmetric so w2 == w0
  localparam logic [3:0] SOBEL_W0   = 4'd1;
  localparam logic [3:0] SOBEL_W1   = 4'd2;
  localparam logic [3:0] PREWITT_W0 = 4'd1;
  localparam logic [3:0] PREWITT_W1 = 4'd1;
  localparam logic [3:0] SCHARR_W0  = 4'd3;
  localparam logic [3:0] SCHARR_W1  = 4'd10;

  // Weight of tap idx (0..2) for the selected kernel; reserved code falls back to Sobel
  function automatic logic [3:0] kernel_weight(input logic [1:0] ksel, input int idx);
    logic outer_tap;
    outer_tap = (idx != 1);
    case (kernel_e'(ksel))
      K_PREWITT: return outer_tap ? PREWITT_W0 : PREWITT_W1;
      K_SCHARR:  return outer_tap ? SCHARR_W0 : SCHARR_W1;
      default:   return outer_tap ? SOBEL_W0 : SOBEL_W1;
    endcase
  endfunction

endpackage

// File: rtl/gradient_dir_quant.sv
// Quantises a gradient (|Gx|, |Gy|, sign disagreement) into one of four directions.
module gradient_dir_quant
  import edge_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic [AW-1:0] ax_i,
  input  logic [AW-1:0] ay_i,
  input  logic          sdiff_i,
  output dir_e          dir_o
);

  localparam int PW = AW + 10;

  logic [PW-1:0] ay_q8;
  logic [PW-1:0] ax_lo;
  logic [PW-1:0] ax_hi;

  assign ay_q8 = PW'(ay_i) << 8;
  assign ax_lo = PW'(ax_i) * PW'(TAN22_Q8);
  assign ax_hi = PW'(ax_i) * PW'(TAN67_Q8);

  // Compare the slope against the 22.5/67.5 degree sector borders; zero gradient lands on DIR_H
  always_comb begin
    dir_o = DIR_H;
    if (ay_q8 <= ax_lo) begin
      dir_o = DIR_H;
    end else if (ay_q8 >= ax_hi) begin
      dir_o = DIR_V;
    end else begin
      dir_o = sdiff_i ? DIR_135 : DIR_45;
    end
  end

endmodule

// File: rtl/gradient_calc_pipe.sv
// 3-stage elastic gradient pipeline: kernel convolution, magnitude, saturation/direction,
// plus a per-frame edge counter on the output handshake.
module gradient_calc_pipe
  import edge_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int MAG_W   = 11,
  parameter int CNT_W   = 19
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [9*PIXEL_W-1:0] win_in,
  input  logic                 win_in_valid,
  output logic                 win_in_ready,
  input  logic                 win_in_sof,
  input  logic [1:0]           kernel_sel,
  input  logic                 mag_sel,
  input  logic [MAG_W-1:0]     edge_thresh,
  output logic [MAG_W-1:0]     gradient_magnitude,
  output logic [1:0]           gradient_direction,
  output logic [PIXEL_W-1:0]   pixel_out_x,
  output logic [PIXEL_W-1:0]   pixel_out_y,
  output logic                 gradient_out_valid,
  input  logic                 gradient_out_ready,
  output logic                 gradient_out_sof,
  output logic [CNT_W-1:0]     edge_count
);

  localparam int GW = PIXEL_W + 6;  // signed Gx/Gy
  localparam int AW = GW - 1;       // |Gx|, |Gy|
  localparam int RW = GW;           // raw magnitude

  function automatic logic [AW-1:0] abs_val(input logic signed [GW-1:0] v);
    return AW'(v[GW-1] ? -v : v);
  endfunction

  function automatic logic [MAG_W-1:0] sat_mag(input logic [RW-1:0] v);
    if (v > RW'({MAG_W{1'b1}})) return '1;
    else return v[MAG_W-1:0];
  endfunction

  function automatic logic [PIXEL_W-1:0] sat_pix(input logic [AW-1:0] v);
    if (v > AW'({PIXEL_W{1'b1}})) return '1;
    else return v[PIXEL_W-1:0];
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic rdy1, rdy2, rdy3;

  assign rdy3               = !vld_p3 || gradient_out_ready;
  assign rdy2               = !vld_p2 || rdy3;
  assign rdy1               = !vld_p1 || rdy2;
  assign win_in_ready       = rdy1;
  assign gradient_out_valid = vld_p3;

  // ---- stage 1: convolution ----
  logic signed [GW-1:0] px [9];
  logic signed [GW-1:0] wt;
  logic signed [GW-1:0] gx_d, gy_d, gx_p1, gy_p1;
  logic                 msel_p1, sof_p1;

  for (genvar k = 0; k < 9; k++) begin : g_unpack
    assign px[k] = $signed({{(GW-PIXEL_W){1'b0}}, win_in[k*PIXEL_W +: PIXEL_W]});
  end

  // Weighted column/row differences for the selected kernel
  always_comb begin
    wt   = '0;
    gx_d = '0;
    gy_d = '0;
    for (int i = 0; i < 3; i++) begin
      wt   = $signed({{(GW-4){1'b0}}, kernel_weight(kernel_sel, i)});
      gx_d = gx_d + wt * (px[3*i+2] - px[3*i]);
      gy_d = gy_d + wt * (px[6+i] - px[i]);
    end
  end

  // Stage 1 valid
  always_ff @(posedge clk) begin
    if (!rstN) vld_p1 <= 1'b0;
    else if (rdy1) vld_p1 <= win_in_valid;
  end

  // Stage 1 data, loaded only on an input transfer
  always_ff @(posedge clk) begin
    if (win_in_valid && rdy1) begin
      gx_p1   <= gx_d;
      gy_p1   <= gy_d;
      msel_p1 <= mag_sel;
      sof_p1  <= win_in_sof;
    end
  end

  // ---- stage 2: absolute values and raw magnitude ----
  logic [AW-1:0] ax_d, ay_d, mx, mn, ax_p2, ay_p2;
  logic [RW-1:0] rawmag_d, rawmag_p2;
  logic          sdiff_p2, sof_p2;

  assign ax_d = abs_val(gx_p1);
  assign ay_d = abs_val(gy_p1);

  // L1 sum, or alpha-max-plus-beta-min L2 approximation (max + 3/8 min, truncating shifts)
  always_comb begin
    mx = ax_d;
    mn = ay_d;
    if (ay_d > ax_d) begin
      mx = ay_d;
      mn = ax_d;
    end
    if (msel_p1) rawmag_d = {1'b0, mx} + RW'(mn >> 2) + RW'(mn >> 3);
    else         rawmag_d = {1'b0, ax_d} + {1'b0, ay_d};
  end

  // Stage 2 valid
  always_ff @(posedge clk) begin
    if (!rstN) vld_p2 <= 1'b0;
    else if (rdy2) vld_p2 <= vld_p1;
  end

  // Stage 2 data
  always_ff @(posedge clk) begin
    if (vld_p1 && rdy2) begin
      ax_p2     <= ax_d;
      ay_p2     <= ay_d;
      sdiff_p2  <= gx_p1[GW-1] ^ gy_p1[GW-1];
      rawmag_p2 <= rawmag_d;
      sof_p2    <= sof_p1;
    end
  end

  // ---- stage 3: saturation, direction, outputs ----
  dir_e dir_d;

  gradient_dir_quant #(.AW(AW)) u_dir (
    .ax_i    (ax_p2),
    .ay_i    (ay_p2),
    .sdiff_i (sdiff_p2),
    .dir_o   (dir_d)
  );

  // Output registers; cleared on reset, held while downstream stalls
  always_ff @(posedge clk) begin
    if (!rstN) begin
      vld_p3             <= 1'b0;
      gradient_magnitude <= '0;
      gradient_direction <= '0;
      pixel_out_x        <= '0;
      pixel_out_y        <= '0;
      gradient_out_sof   <= 1'b0;
    end else if (rdy3) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        gradient_magnitude <= sat_mag(rawmag_p2);
        gradient_direction <= dir_d;
        pixel_out_x        <= sat_pix(ax_p2);
        pixel_out_y        <= sat_pix(ay_p2);
        gradient_out_sof   <= sof_p2;
      end
    end
  end

  // ---- edge counter ----
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             out_fire, hit;

  assign out_fire   = vld_p3 && gradient_out_ready;
  assign hit        = (gradient_magnitude >= edge_thresh);
  assign edge_count = edge_count_q;

  // Restart on a frame's first output, otherwise saturating accumulate
  always_comb begin
    edge_count_d = edge_count_q;
    if (out_fire) begin
      if (gradient_out_sof)   edge_count_d = CNT_W'(hit);
      else if (!(&edge_count_q)) edge_count_d = edge_count_q + CNT_W'(hit);
    end
  end

  // Edge counter register
  always_ff @(posedge clk) begin
    if (!rstN) edge_count_q <= '0;
    else       edge_count_q <= edge_count_d;
  end

endmodule
